// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment readback decoder
// Contents: digit pattern table (gfedcba, index = digit code), blank pattern,
//           default stability threshold.
package seg7_pkg;

  // Default number of consecutive identical samples before a pattern is accepted.
  localparam int STABLE_CYCLES_DEFAULT = 4;

  // Segment patterns for codes 7..0 (packed, so element [i] is the pattern for code i).
  localparam logic [7:0][6:0] DIGIT_PATTERNS = {
    7'b0000111,   // 7
    7'b1111101,   // 6
    7'b1101101,   // 5
    7'b1100110,   // 4
    7'b1001111,   // 3
    7'b1011011,   // 2
    7'b0000110,   // 1
    7'b0111111    // 0
  };

  // Blank reading: all segments off, qualified by none=1.
  localparam logic [6:0] BLANK_PATTERN = 7'b0000000;

endpackage

// File: rtl/seg7_classify.sv
// rtl/seg7_classify.sv - combinational classifier for a sampled 7-segment pattern
// Ports:
//   none      in  1  "no data" indicator
//   segments  in  7  pattern, gfedcba (bit 0 = a)
//   code      out 3  digit index 0..7, 0 for blank or illegal
//   legal     out 1  pattern is one of the eight digits (none=0) or the blank
//   blank     out 1  pattern is the blank reading
module seg7_classify
  import seg7_pkg::*;
(
  input  logic       none,
  input  logic [6:0] segments,
  output logic [2:0] code,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    code  = 3'd0;
    legal = 1'b0;
    blank = 1'b0;
    if (none) begin
      // With none set, only the all-off pattern is meaningful.
      if (segments == BLANK_PATTERN) begin
        legal = 1'b1;
        blank = 1'b1;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (segments == DIGIT_PATTERNS[i]) begin
          legal = 1'b1;
          code  = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// rtl/seg7_readback_decoder.sv - debounced 7-segment readback decoder with valid/ready output
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   segments, none sampled display pattern (gfedcba) and "no data" indicator
//   out_valid/out_ready  handshake for a decoded reading
//   out_code, out_onehot, out_blank  decoded reading, held while out_valid
//   err_pulse      one-cycle pulse per accepted illegal pattern
//   err_count      saturating count of accepted illegal patterns
//   overrun        sticky: a new legal reading was dropped while one was pending
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic       none,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic [7:0] out_onehot,
  output logic       out_blank,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       overrun
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [7:0] sample;
  logic [7:0] s_q;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       changed;
  logic       accept;
  logic       accept_q;

  logic [7:0] last_q;
  logic       last_vld;

  logic [2:0] cls_code;
  logic       cls_legal;
  logic       cls_blank;
  logic [7:0] cls_onehot;
  logic       new_reading;
  logic       load;
  logic       drop;
  logic       handshake;

  assign sample = {none, segments};

  // Classification runs on s_q: the edge after acceptance, s_q still holds
  // the accepted pattern even if the input has already moved on.
  seg7_classify u_classify (
    .none     (s_q[7]),
    .segments (s_q[6:0]),
    .code     (cls_code),
    .legal    (cls_legal),
    .blank    (cls_blank)
  );

  always_comb begin
    changed  = (sample != s_q);
    cnt_next = cnt;
    if (changed) begin
      cnt_next = 4'd1;
    end else if (cnt >= STABLE_CNT) begin
      cnt_next = STABLE_CNT;
    end else begin
      cnt_next = cnt + 4'd1;
    end
    // Fire only on the step into the threshold; a held pattern sits at the
    // saturated value and never re-fires. The 'changed' term covers a
    // threshold of 1, where a fresh pattern reloads the same value.
    accept = (cnt_next == STABLE_CNT) && (changed || (cnt != STABLE_CNT));
  end

  always_comb begin
    cls_onehot  = cls_blank ? 8'h00 : (8'h01 << cls_code);
    new_reading = accept_q && cls_legal && (!last_vld || (last_q != s_q));
    handshake   = out_valid && out_ready;
    load        = new_reading && (!out_valid || out_ready);
    drop        = new_reading && out_valid && !out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 8'h00;
      cnt        <= 4'd0;
      accept_q   <= 1'b0;
      last_q     <= 8'h00;
      last_vld   <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= 3'd0;
      out_onehot <= 8'h00;
      out_blank  <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      s_q      <= sample;
      cnt      <= cnt_next;
      accept_q <= accept;

      err_pulse <= accept_q && !cls_legal;
      if (accept_q && !cls_legal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (drop) begin
        overrun <= 1'b1;
      end

      if (load) begin
        out_valid  <= 1'b1;
        out_code   <= cls_code;
        out_onehot <= cls_onehot;
        out_blank  <= cls_blank;
        last_q     <= s_q;
        last_vld   <= 1'b1;
      end else if (handshake) begin
        out_valid  <= 1'b0;
        out_code   <= 3'd0;
        out_onehot <= 8'h00;
        out_blank  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// tb/tb_seg7_readback_decoder.sv - scoreboard bench for seg7_readback_decoder
module tb_seg7_readback_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] segments;
  logic       none;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [7:0] out_onehot;
  logic       out_blank;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  logic [6:0] digits [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

  seg7_readback_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .segments   (segments),
    .none       (none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_onehot (out_onehot),
    .out_blank  (out_blank),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] expect_digit(input int i);
    logic [7:0] oh;
    oh = 8'h01 << i;
    return {3'(i), oh, 1'b0};
  endfunction

  task automatic drive(input logic [6:0] s, input logic n);
    segments = s;
    none     = n;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshake monitor: a reading is consumed at the edge following a negedge
  // where out_valid & out_ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("reading", {20'd0, out_code, out_onehot, out_blank}, {20'd0, mon_exp});
      end
    end
    if (!rst && err_pulse) err_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(7'd0, 1'b0);
    cycles(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(out_code), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_blank", 32'(out_blank), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Code 6 with out_ready low: appears after edge 4 and is held.
    rst = 1'b0;
    drive(digits[6], 1'b0);
    exp_q.push_back(expect_digit(6));
    cycles(4);
    check("latency_early", 32'(out_valid), 32'd0);
    cycles(1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("code6", 32'(out_code), 32'd6);
    check("onehot6", 32'(out_onehot), 32'h40);
    check("blank6", 32'(out_blank), 32'd0);
    cycles(2);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_code", 32'(out_code), 32'd6);

    // Single-cycle ready pulse, same pattern held: no re-report.
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("hs_drop_valid", 32'(out_valid), 32'd0);
    check("hs_clear_onehot", 32'(out_onehot), 32'd0);
    cycles(10);
    check("no_rereport", 32'(out_valid), 32'd0);

    // Blank reading, then a short glitch back to blank.
    out_ready = 1'b1;
    drive(7'd0, 1'b1);
    exp_q.push_back({3'd0, 8'h00, 1'b1});
    cycles(5);
    check("blank_valid", 32'(out_valid), 32'd1);
    check("blank_flag", 32'(out_blank), 32'd1);
    check("blank_code", 32'(out_code), 32'd0);
    check("blank_onehot", 32'(out_onehot), 32'd0);
    cycles(3);
    drive(digits[1], 1'b0);
    cycles(2);
    drive(7'd0, 1'b1);
    cycles(8);
    check("glitch_no_err", 32'(err_count), 32'd0);
    check("glitch_no_output", 32'(exp_q.size()), 32'd0);

    // Illegal patterns.
    drive(7'b0000110, 1'b1);
    cycles(6);
    drive(7'h7F, 1'b0);
    cycles(6);
    check("err_count2", 32'(err_count), 32'd2);
    check("err_pulses2", 32'(err_seen), 32'd2);
    check("err_no_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) drive(7'h01, 1'b1);
      else            drive(7'h7F, 1'b0);
      cycles(4);
    end
    cycles(3);
    check("err_saturate", 32'(err_count), 32'd255);
    check("err_pulses302", 32'(err_seen), 32'd302);

    // Overrun: code 3 pending, code 5 dropped.
    out_ready = 1'b0;
    drive(digits[3], 1'b0);
    exp_q.push_back(expect_digit(3));
    cycles(6);
    check("ovr_first_valid", 32'(out_valid), 32'd1);
    check("ovr_first_code", 32'(out_code), 32'd3);
    check("ovr_clear_before", 32'(overrun), 32'd0);
    drive(digits[5], 1'b0);
    cycles(6);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_code_held", 32'(out_code), 32'd3);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("ovr_drained", 32'(out_valid), 32'd0);

    // Pending reading discarded by reset.
    drive(digits[4], 1'b0);
    cycles(6);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_code", 32'(out_code), 32'd4);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_code", 32'(out_code), 32'd0);
    check("mid_rst_onehot", 32'(out_onehot), 32'd0);
    check("mid_rst_blank", 32'(out_blank), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);

    // Sweep all digits with out_ready high.
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(digits[i], 1'b0);
      exp_q.push_back(expect_digit(i));
      cycles(6);
    end
    cycles(2);
    check("sweep_drained", 32'(exp_q.size()), 32'd0);
    check("sweep_no_err", 32'(err_count), 32'd0);
    check("sweep_no_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_readback_decoder.md
# seg7_readback_decoder

Inverse of the team's 8-bit priority encoder / 7-segment driver. The block samples a 7-segment pattern (segments gfedcba plus the "none" indicator) and debounces it. It decodes it back to a 3-bit index and a one-hot 8-bit value, and delivers each newly stable, legal reading over a valid/ready handshake. Illegal or conflicting patterns are counted. It sits on the readback/self-test path: display-bus monitoring, loopback checks of the encoder, or decoding an external display.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples (1..15) required before a pattern is accepted.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- segments  in  7  sampled pattern, bit order gfedcba (bit 0 = a).
- none  in  1  "no data" indicator (decimal point).
- out_valid  out  1  a decoded reading is pending.
- out_ready  in  1  consumer accepts the reading when out_valid & out_ready.
- out_code  out  3  decoded index 0..7; 0 when out_blank.
- out_onehot  out  8  1 << out_code, or 8'h00 when out_blank.
- out_blank  out  1  reading was "none" (segments all off, none=1).
- err_pulse  out  1  one-cycle pulse when an illegal pattern is accepted.
- err_count  out  8  saturating count of illegal accepted patterns.
- overrun  out  1  sticky: a legal reading was dropped because out_valid was still pending.

## Operation
- Legal patterns: the eight digit codes with none=0. Code 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111. Blank is segments = 0000000 with none=1.
- Every other {none, segments} combination is illegal. This includes any nonzero segments with none=1, and all-zero segments with none=0.
- Input register s_q captures {none, segments} every cycle.
- Stability counter cnt, 4 bits:
  - loads 1 when the incoming sample differs from s_q;
  - otherwise increments, saturating at STABLE_CYCLES.
- Acceptance event: the single cycle in which cnt transitions to STABLE_CYCLES. A held pattern is accepted exactly once.
- On acceptance of an illegal pattern:
  - err_pulse is asserted for 1 cycle;
  - err_count increments, saturating at 255;
  - nothing is emitted and last_reported is unchanged.
- On acceptance of a legal pattern equal to last_reported: no action.
- On acceptance of a legal pattern that differs:
  - If out_valid=0, or out_valid & out_ready in the same cycle: load the outputs, set out_valid=1, and update last_reported.
  - If out_valid=1 & out_ready=0: drop the reading, set overrun=1, and leave last_reported unchanged.
- Output hold: out_code, out_onehot and out_blank stay stable while out_valid=1 and are cleared to 0 on a handshake with no new load.
- Simultaneous handshake and new load: the new reading replaces the old, and out_valid stays 1.

## Timing
- Reset (rst=1 at an edge) values:
  - out_valid = 0, out_code = 0, out_onehot = 0, out_blank = 0;
  - err_pulse = 0, err_count = 0, overrun = 0;
  - s_q = 0, cnt = 0;
  - last_reported = "nothing", so the first legal acceptance is always reported.
- Reset mid-operation discards a pending reading and any partial stability count.
- Latency: an input stable from before edge 0 is captured at edge 0 (cnt=1). It is accepted at edge STABLE_CYCLES−1. out_valid or err_pulse appears after edge STABLE_CYCLES, i.e. 5 edges for the default.
- A glitch of fewer than STABLE_CYCLES samples produces no output and no error.
- Returning to the previously reported pattern after a glitch produces no output.
- out_valid is deasserted the edge after the handshake.

## Structure
- Package seg7_pkg holds:
  - the 8-entry digit pattern constant array (gfedcba);
  - the BLANK pattern constant;
  - the default STABLE_CYCLES.
- Sub-module seg7_classify is combinational. It maps {none, segments} to code[2:0], legal and blank.
- The top level holds the sampler, stability counter, handshake register and error logic.

## Test plan
- Reset, then hold segments=1111101, none=0 for 6 cycles with out_ready=0 -> out_valid=1 after edge 4, out_code=6, out_onehot=8'h40, out_blank=0, held.
- From that state, pulse out_ready for 1 cycle, then hold the same pattern -> out_valid drops the next edge and no re-report occurs.
- segments=0000000, none=1 stable -> out_blank=1, out_code=0, out_onehot=8'h00. Then 2-cycle glitch to 0000110 -> no output, no error.
- segments=0000110, none=1 stable, then segments=1111111, none=0 stable -> two err_pulses, err_count=2, out_valid stays 0. Force 300 illegal acceptances -> err_count=255.
- out_ready=0, then apply code 3 and then code 5, each stable -> first is reported (out_code=3), second is dropped, overrun=1. Assert rst mid-sequence -> all outputs 0.
- Sweep all 8 digit codes with out_ready=1 -> each yields out_onehot = 1 << index exactly once.
